// File: rtl/msk_ref_pkg.sv
// rtl/msk_ref_pkg.sv - shared helpers for the masked refresh pipeline
package msk_ref_pkg;

    // Widest sharing the lane mask helper has to cover.
    localparam int MAX_D = 16;

    // Random bits consumed per lane: one bit suffices for two shares,
    // otherwise one bit per share feeds the ring refresh.
    function automatic int nr_of(input int d);
        return (d == 2) ? 1 : d;
    endfunction

    // Zero-sum lane mask from a lane's random slice (bits above nr ignored).
    // Two shares: both shares flip by the same bit.
    // Three or more: ring refresh m[j] = r[j] ^ r[j-1 mod d], each r bit
    // enters exactly two mask bits so the XOR over the lane cancels.
    function automatic logic [MAX_D-1:0] lane_mask(input logic [MAX_D-1:0] r,
                                                   input int d);
        logic [MAX_D-1:0] one;
        logic [MAX_D-1:0] valid_bits;
        logic [MAX_D-1:0] prev;
        logic [MAX_D-1:0] m;
        one        = {{(MAX_D-1){1'b0}}, 1'b1};
        valid_bits = (one << d) - one;
        m          = '0;
        if (d == 2) begin
            m[0] = r[0];
            m[1] = r[0];
        end else begin
            // prev[j] = r[j-1] for j >= 1, prev[0] wraps to r[d-1]
            prev = ((r << 1) | ((r >> (d - 1)) & one)) & valid_bits;
            m    = (r ^ prev) & valid_bits;
        end
        return m;
    endfunction

endpackage

// File: rtl/msk_ref_mask.sv
// rtl/msk_ref_mask.sv - combinational zero-sum mask for one lane
module msk_ref_mask
    import msk_ref_pkg::*;
#(
    parameter int d  = 2,
    parameter int nr = 1
) (
    input  logic [nr-1:0] r,
    output logic [d-1:0]  m
);

    logic [MAX_D-1:0] r_ext;
    logic [MAX_D-1:0] m_ext;
    logic             unused_m_par;

    // Widen the lane's random slice to the helper width and keep d shares.
    always_comb begin
        r_ext         = '0;
        r_ext[nr-1:0] = r;
        m_ext         = lane_mask(r_ext, d);
        m             = m_ext[d-1:0];
    end

    // Upper helper bits are always zero; fold them so nothing dangles.
    assign unused_m_par = ^m_ext;

endmodule

// File: rtl/msk_ref_pipe.sv
// rtl/msk_ref_pipe.sv - one-stage share refresh with registered randomness
module msk_ref_pipe
    import msk_ref_pkg::*;
#(
    parameter int d     = 2,
    parameter int nbits = 1,
    parameter int CNT_W = 16
) (
    (* fv_type = "clock" *)
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    (* fv_type = "sharing" *)
    input  logic [nbits*d-1:0]       in,
    input  logic                     rnd_valid,
    output logic                     rnd_ready,
    (* fv_type = "random" *)
    input  logic [nbits*nr_of(d)-1:0] rnd,
    output logic                     out_valid,
    input  logic                     out_ready,
    (* fv_type = "sharing" *)
    output logic [nbits*d-1:0]       out,
    output logic [CNT_W-1:0]         n_done
);

    localparam int nr = nr_of(d);

    logic [nbits*d-1:0] mask_new;

    (* keep = "true", preserve = "true" *)
    logic [nbits*d-1:0] mask_buf_q;
    logic [nbits*d-1:0] mask_buf_d;
    logic               mask_full_q;
    logic               mask_full_d;
    (* keep = "true", preserve = "true" *)
    logic [nbits*d-1:0] out_q;
    logic [nbits*d-1:0] out_d;
    logic               out_valid_q;
    logic               out_valid_d;
    logic [CNT_W-1:0]   n_done_q;
    logic [CNT_W-1:0]   n_done_d;

    logic in_fire;
    logic rnd_fire;
    logic out_fire;

    // One mask generator per lane; the result only ever lands in the buffer.
    for (genvar i = 0; i < nbits; i++) begin : g_lane
        msk_ref_mask #(
            .d  (d),
            .nr (nr)
        ) u_mask (
            .r (rnd[i*nr +: nr]),
            .m (mask_new[i*d +: d])
        );
    end

    // Input acceptance depends only on registered state, never on valids.
    assign in_ready  = mask_full_q && (!out_valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign rnd_ready = !mask_full_q || in_fire;
    assign rnd_fire  = rnd_valid && rnd_ready;
    assign out_fire  = out_valid_q && out_ready;

    // Next-state: refill/consume the mask buffer, load output, count drains.
    always_comb begin
        mask_buf_d  = mask_buf_q;
        mask_full_d = mask_full_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        n_done_d    = n_done_q;

        // Consume first so a same-cycle reload keeps the buffer full.
        if (in_fire) begin
            mask_full_d = 1'b0;
        end
        if (rnd_fire) begin
            mask_buf_d  = mask_new;
            mask_full_d = 1'b1;
        end

        // The applied mask is the buffered one, never this cycle's rnd.
        if (in_fire) begin
            out_d       = in ^ mask_buf_q;
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (out_fire && (n_done_q != {CNT_W{1'b1}})) begin
            n_done_d = n_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_buf_q  <= '0;
            mask_full_q <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            n_done_q    <= '0;
        end else begin
            mask_buf_q  <= mask_buf_d;
            mask_full_q <= mask_full_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            n_done_q    <= n_done_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign n_done    = n_done_q;

endmodule

// File: tb/tb_msk_ref_pipe.sv
// tb/tb_msk_ref_pipe.sv - directed and table-driven checks of msk_ref_pipe
module tb_msk_ref_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // d=2, nbits=1, CNT_W=4
    logic       in_valid2, in_ready2, rnd_valid2, rnd_ready2, out_valid2, out_ready2;
    logic [1:0] in2, out2;
    logic [0:0] rnd2;
    logic [3:0] n_done2;

    // d=3, nbits=1
    logic        in_valid3, in_ready3, rnd_valid3, rnd_ready3, out_valid3, out_ready3;
    logic [2:0]  in3, out3, rnd3;
    logic [15:0] n_done3;

    // d=4, nbits=8
    logic        in_valid4, in_ready4, rnd_valid4, rnd_ready4, out_valid4, out_ready4;
    logic [31:0] in4, out4, rnd4;
    logic [15:0] n_done4;

    msk_ref_pipe #(.d(2), .nbits(1), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in(in2),
        .rnd_valid(rnd_valid2), .rnd_ready(rnd_ready2), .rnd(rnd2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out(out2),
        .n_done(n_done2)
    );

    msk_ref_pipe #(.d(3), .nbits(1), .CNT_W(16)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in(in3),
        .rnd_valid(rnd_valid3), .rnd_ready(rnd_ready3), .rnd(rnd3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out(out3),
        .n_done(n_done3)
    );

    msk_ref_pipe #(.d(4), .nbits(8), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in(in4),
        .rnd_valid(rnd_valid4), .rnd_ready(rnd_ready4), .rnd(rnd4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out(out4),
        .n_done(n_done4)
    );

    // Independent ring-refresh model for d=4: m[j] = r[j] ^ r[(j+3)%4]
    function automatic logic [31:0] model_mask4(input logic [31:0] r);
        logic [31:0] m;
        logic [3:0]  n;
        m = '0;
        for (int l = 0; l < 8; l++) begin
            n = r[l*4 +: 4];
            m[l*4 +: 4] = n ^ {n[2:0], n[3]};
        end
        return m;
    endfunction

    // Scoreboard for the d=4 instance
    logic [31:0] mask_q[$];
    logic [31:0] exp_q[$];
    int in_cnt4  = 0;
    int out_cnt4 = 0;

    always @(negedge clk) begin
        logic [31:0] m;
        logic [31:0] e;
        if (out_valid4 && out_ready4) begin
            check("u4_out_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("u4_out", 64'(out4), 64'(e));
            end
            out_cnt4++;
        end
        if (in_valid4 && in_ready4) begin
            check("u4_mask_loaded", 64'(mask_q.size() > 0), 64'd1);
            m = (mask_q.size() > 0) ? mask_q.pop_front() : 32'h0;
            exp_q.push_back(in4 ^ m);
            in_cnt4++;
        end
        if (rnd_valid4 && rnd_ready4) begin
            mask_q.push_back(model_mask4(rnd4));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [2:0] r;
        logic [2:0] i;
        logic [2:0] o;
    } vec3_t;

    vec3_t tbl[6];
    int    cnt;
    int    saved;
    logic [31:0] hold4;

    initial begin
        tbl[0] = '{r: 3'b011, i: 3'b001, o: 3'b100};
        tbl[1] = '{r: 3'b110, i: 3'b111, o: 3'b100};
        tbl[2] = '{r: 3'b111, i: 3'b010, o: 3'b010};
        tbl[3] = '{r: 3'b000, i: 3'b101, o: 3'b101};
        tbl[4] = '{r: 3'b001, i: 3'b000, o: 3'b011};
        tbl[5] = '{r: 3'b100, i: 3'b110, o: 3'b011};

        rst = 1'b1;
        in_valid2 = 0; rnd_valid2 = 0; out_ready2 = 1; in2 = '0; rnd2 = '0;
        in_valid3 = 0; rnd_valid3 = 0; out_ready3 = 1; in3 = '0; rnd3 = '0;
        in_valid4 = 0; rnd_valid4 = 0; out_ready4 = 1; in4 = '0; rnd4 = '0;
        tick;
        tick;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready2",  64'(in_ready2),  64'd0);
        check("rst_rnd_ready2", 64'(rnd_ready2), 64'd1);
        check("rst_out_valid2", 64'(out_valid2), 64'd0);
        check("rst_out2",       64'(out2),       64'd0);
        check("rst_n_done2",    64'(n_done2),    64'd0);
        check("rst_in_ready3",  64'(in_ready3),  64'd0);

        // d=2: rnd=1 -> mask 11; in=01 -> out=10
        tick;
        rnd_valid2 = 1; rnd2 = 1'b1;
        tick;
        rnd_valid2 = 0; in_valid2 = 1; in2 = 2'b01;
        @(negedge clk);
        check("d2_in_ready_loaded", 64'(in_ready2), 64'd1);
        tick;
        in_valid2 = 0;
        @(negedge clk);
        check("d2_out_valid", 64'(out_valid2), 64'd1);
        check("d2_out",       64'(out2),       64'd2);
        check("d2_n_done0",   64'(n_done2),    64'd0);
        check("d2_in_ready_empty", 64'(in_ready2), 64'd0);
        tick;
        @(negedge clk);
        check("d2_out_valid_clr", 64'(out_valid2), 64'd0);
        check("d2_n_done1",       64'(n_done2),    64'd1);

        // Reset in the same cycle as in_fire
        tick;
        rnd_valid2 = 1; rnd2 = 1'b0;
        tick;
        rnd_valid2 = 0; in_valid2 = 1; in2 = 2'b11; rst = 1'b1;
        @(negedge clk);
        check("rstfire_in_ready", 64'(in_ready2), 64'd1);
        tick;
        rst = 1'b0; in_valid2 = 0;
        @(negedge clk);
        check("rstfire_out_valid", 64'(out_valid2), 64'd0);
        check("rstfire_n_done",    64'(n_done2),    64'd0);
        check("rstfire_in_ready0", 64'(in_ready2),  64'd0);

        // Saturation of a 4-bit counter
        tick;
        rnd_valid2 = 1; in_valid2 = 1; rnd2 = 1'($urandom); in2 = 2'($urandom);
        cnt = 0;
        for (int k = 0; k < 80 && cnt < 20; k++) begin
            @(negedge clk);
            if (out_valid2 && out_ready2) cnt++;
            tick;
            rnd2 = 1'($urandom); in2 = 2'($urandom);
        end
        rnd_valid2 = 0; in_valid2 = 0;
        tick;
        tick;
        @(negedge clk);
        check("sat_handshakes", 64'(cnt),     64'd20);
        check("sat_n_done",     64'(n_done2), 64'hF);

        // d=3 vector table
        for (int v = 0; v < 6; v++) begin
            tick;
            rnd_valid3 = 1; rnd3 = tbl[v].r; in_valid3 = 0;
            tick;
            rnd_valid3 = 0; in_valid3 = 1; in3 = tbl[v].i;
            tick;
            in_valid3 = 0;
            @(negedge clk);
            check($sformatf("d3_vec%0d_valid", v), 64'(out_valid3), 64'd1);
            check($sformatf("d3_vec%0d_out", v),   64'(out3),       64'(tbl[v].o));
        end
        tick;
        tick;

        // d=4, nbits=8 streaming throughput
        rnd_valid4 = 1; in_valid4 = 1; out_ready4 = 1;
        rnd4 = $urandom; in4 = $urandom;
        saved = in_cnt4;
        for (int i = 0; i < 100; i++) begin
            tick;
            rnd4 = $urandom; in4 = $urandom;
        end
        check("u4_throughput", 64'((in_cnt4 - saved) >= 99), 64'd1);

        // Back-pressure: output held, no input or randomness accepted
        out_ready4 = 0;
        @(negedge clk);
        hold4 = out4;
        check("stall_in_ready_first", 64'(in_ready4), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick;
            rnd4 = $urandom; in4 = $urandom;
            @(negedge clk);
            check($sformatf("stall%0d_out", i),       64'(out4),       64'(hold4));
            check($sformatf("stall%0d_valid", i),     64'(out_valid4), 64'd1);
            check($sformatf("stall%0d_in_ready", i),  64'(in_ready4),  64'd0);
            check($sformatf("stall%0d_rnd_ready", i), 64'(rnd_ready4), 64'd0);
        end

        // Release and drain
        saved = in_cnt4;
        tick;
        out_ready4 = 1;
        for (int i = 0; i < 4; i++) begin
            tick;
            rnd4 = $urandom; in4 = $urandom;
        end
        in_valid4 = 0; rnd_valid4 = 0;
        tick;
        tick;
        tick;
        @(negedge clk);
        check("resume_accepts",  64'(in_cnt4 > saved),  64'd1);
        check("drain_empty",     64'(exp_q.size()),     64'd0);
        check("u4_n_done",       64'(n_done4),          64'(out_cnt4));
        check("d3_n_done",       64'(n_done3),          64'd6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/msk_ref_pipe.md
MSK_REF_PIPE -- requirements
Module: msk_ref_pipe

Interface
REQ-001 SHALL have parameter d, default 2, meaning number of shares; legal range 2..16.
REQ-002 SHALL have parameter nbits, default 1, meaning number of independently masked bits (lanes); legal range 1..64.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the completed-refresh counter.
REQ-004 SHALL derive nr = 1 when d==2 and nr = d otherwise, as random bits per lane.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in (input, nbits*d), where in[i*d +: d] is the sharing of lane i.
REQ-008 SHALL have ports rnd_valid (input, 1), rnd_ready (output, 1) and rnd (input, nbits*nr), where lane i uses rnd[i*nr +: nr].
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out (output, nbits*d), with the same layout as in.
REQ-010 SHALL have port n_done (output, CNT_W): count of completed output handshakes.

Function
REQ-011 SHALL compute each lane's mask m from its slice r as follows:
- d==2: m = {r[0], r[0]};
- d>=3: m[j] = r[j] ^ r[(j-1) mod d].
REQ-012 SHALL guarantee that the XOR over the d bits of every lane mask is 0, so the unmasked value is preserved.
REQ-013 SHALL hold one registered mask buffer (nbits*d bits) plus a flag mask_full.
REQ-014 SHALL drive rnd_ready = !mask_full || in_fire.
REQ-015 SHALL load the buffer with the mask of rnd on each rnd_valid && rnd_ready edge.
REQ-016 SHALL drive in_ready = mask_full && (!out_valid || out_ready); in_ready SHALL NOT depend combinationally on in_valid or rnd_valid.
REQ-017 SHALL define in_fire = in_valid && in_ready.
REQ-018 SHALL, on in_fire, register out <= in ^ mask buffer, set out_valid, and consume the buffer:
- mask_full clears unless the buffer is reloaded in the same cycle.
REQ-019 SHALL never apply a mask computed from rnd in the same cycle; randomness is registered at least one cycle before use.
REQ-020 SHALL have a latency of 1 cycle from in_fire to out_valid.
REQ-021 SHALL sustain one transaction per cycle when rnd_valid, in_valid and out_ready are held high.
REQ-022 SHALL clear out_valid on out_valid && out_ready when there is no simultaneous in_fire.
REQ-023 SHALL hold out and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL use each mask for exactly one transaction; no mask reuse, and no rnd consumption while the buffer is full and not being consumed.
REQ-025 SHALL increment n_done on each out_valid && out_ready and saturate at all-ones (no wrap).
REQ-026 SHALL annotate ports for the formal flow:
- in, out: sharing;
- rnd: random;
- clk: clock;
- mask buffer and out registers: preserve/keep.

Reset
REQ-027 SHALL, when rst is high at a clock edge, set mask_full=0, out_valid=0, out=0, mask buffer=0 and n_done=0, overriding any simultaneous handshake.
REQ-028 SHALL drive in_ready=0 in the cycle after reset, because the buffer is empty; an in-flight transaction at reset is discarded.

Structure
REQ-029 SHALL place the nr derivation function and the per-lane mask function in package msk_ref_pkg.
REQ-030 SHALL implement the per-lane mask generation as combinational sub-module msk_ref_mask, instantiated nbits times.

Verification
REQ-031 SHALL cover: d=2, nbits=1, rnd=1'b1 loaded, then in=2'b01 -> out=2'b10 one cycle after in_fire; n_done=1 after out handshake.
REQ-032 SHALL cover: d=3, nbits=1, rnd=3'b011 -> mask 3'b101; in=3'b001 -> out=3'b100.
REQ-033 SHALL cover: d=4, nbits=8, all valids and out_ready high for 100 cycles -> 99 or more outputs, each lane's share-XOR equal to the input's, no repeated mask slice.
REQ-034 SHALL cover: out_ready=0 for 5 cycles with out_valid=1 -> out stable, in_ready=0, rnd_ready=0 once the buffer is full; release -> transfer resumes.
REQ-035 SHALL cover: rst asserted in the same cycle as in_fire -> next cycle out_valid=0, n_done=0, in_ready=0.
REQ-036 SHALL cover: CNT_W=4, 20 completed transactions -> n_done=4'hF.
